// File: rtl/serdesphy_seq_pkg.sv
// Shared definitions for the SerDes PHY link sequencer: state encodings and
// the output bundle with its safe (powered-down) value.
package serdesphy_seq_pkg;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StPwrWait   = 4'd1,
        StPllRst    = 4'd2,
        StPllWait   = 4'd3,
        StTrxEn     = 4'd4,
        StCdrWait   = 4'd5,
        StAlignWait = 4'd6,
        StReady     = 4'd7,
        StFault     = 4'd8
    } seq_state_e;

    typedef struct packed {
        logic iso_en;
        logic pll_rst;
        logic tx_en;
        logic rx_en;
        logic cdr_rst;
        logic rx_align_rst;
        logic phy_ready;
    } seq_out_t;

    localparam seq_out_t SafeOut = '{
        iso_en:       1'b1,
        pll_rst:      1'b1,
        tx_en:        1'b0,
        rx_en:        1'b0,
        cdr_rst:      1'b1,
        rx_align_rst: 1'b1,
        phy_ready:    1'b0
    };

    // Each bring-up state releases one more control on top of the previous one.
    function automatic seq_out_t state_outputs(input seq_state_e st);
        seq_out_t o;
        o = SafeOut;
        unique case (st)
            StPllRst: begin
                o.iso_en = 1'b0;
            end
            StPllWait: begin
                o.iso_en  = 1'b0;
                o.pll_rst = 1'b0;
            end
            StTrxEn: begin
                o.iso_en  = 1'b0;
                o.pll_rst = 1'b0;
                o.tx_en   = 1'b1;
                o.rx_en   = 1'b1;
            end
            StCdrWait: begin
                o.iso_en  = 1'b0;
                o.pll_rst = 1'b0;
                o.tx_en   = 1'b1;
                o.rx_en   = 1'b1;
                o.cdr_rst = 1'b0;
            end
            StAlignWait: begin
                o.iso_en       = 1'b0;
                o.pll_rst      = 1'b0;
                o.tx_en        = 1'b1;
                o.rx_en        = 1'b1;
                o.cdr_rst      = 1'b0;
                o.rx_align_rst = 1'b0;
            end
            StReady: begin
                o.iso_en       = 1'b0;
                o.pll_rst      = 1'b0;
                o.tx_en        = 1'b1;
                o.rx_en        = 1'b1;
                o.cdr_rst      = 1'b0;
                o.rx_align_rst = 1'b0;
                o.phy_ready    = 1'b1;
            end
            default: o = SafeOut;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/serdesphy_seq_timer.sv
// Clear/enable saturating state timer; hit flags the last cycle of a
// limit-cycle window (count == limit-1).
module serdesphy_seq_timer #(
    parameter int unsigned TIMER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TIMER_W:0] limit,
    output logic             hit
);

    logic [TIMER_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit wraps to all-ones in TIMER_W+1 bits and can never match.
    assign hit = ({1'b0, count_q} == (limit - 1'b1));

endmodule

// File: rtl/serdesphy_link_sequencer.sv
// SerDes PHY bring-up/recovery sequencer: ordered power-up with per-state
// timeouts, bounded retries, and registered Moore output decode.
module serdesphy_link_sequencer
    import serdesphy_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 48,
    parameter int unsigned PLL_TIMEOUT   = 2400,
    parameter int unsigned CDR_TIMEOUT   = 4800,
    parameter int unsigned ALIGN_TIMEOUT = 2400,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned TIMER_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phy_en,
    input  logic       power_good,
    input  logic       por_complete,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       rx_aligned,
    output logic       iso_en,
    output logic       pll_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       cdr_rst,
    output logic       rx_align_rst,
    output logic       phy_ready,
    output logic       seq_busy,
    output logic       seq_error,
    output logic [3:0] seq_state,
    output logic [3:0] retry_cnt
);

    localparam logic [3:0]       MaxRetries = 4'(MAX_RETRIES);
    localparam logic [TIMER_W:0] SettleLim  = (TIMER_W + 1)'(SETTLE_CYCLES);
    localparam logic [TIMER_W:0] PllLim     = (TIMER_W + 1)'(PLL_TIMEOUT);
    localparam logic [TIMER_W:0] CdrLim     = (TIMER_W + 1)'(CDR_TIMEOUT);
    localparam logic [TIMER_W:0] AlignLim   = (TIMER_W + 1)'(ALIGN_TIMEOUT);

    seq_state_e       state_d, state_q;
    logic [3:0]       retry_d, retry_q;
    logic             error_d, error_q;
    logic             busy_d, busy_q;
    seq_out_t         out_d, out_q;
    logic             do_retry;
    logic             timer_clr;
    logic             timer_hit;
    logic [TIMER_W:0] timer_limit;

    always_comb begin
        timer_limit = '0;
        unique case (state_q)
            StPllRst, StTrxEn: timer_limit = SettleLim;
            StPllWait:         timer_limit = PllLim;
            StCdrWait:         timer_limit = CdrLim;
            StAlignWait:       timer_limit = AlignLim;
            default:           timer_limit = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        error_d  = error_q;
        do_retry = 1'b0;

        if (!phy_en) begin
            state_d = StIdle;
            retry_d = '0;
            error_d = 1'b0;
        end else if (!power_good && (state_q != StIdle) && (state_q != StFault)) begin
            state_d = StPwrWait;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StPwrWait;
                StPwrWait: if (power_good && por_complete) state_d = StPllRst;
                StPllRst:  if (timer_hit) state_d = StPllWait;
                StPllWait: begin
                    if (pll_lock)       state_d  = StTrxEn;
                    else if (timer_hit) do_retry = 1'b1;
                end
                StTrxEn: begin
                    if (!pll_lock)      do_retry = 1'b1;
                    else if (timer_hit) state_d  = StCdrWait;
                end
                StCdrWait: begin
                    if (!pll_lock)      do_retry = 1'b1;
                    else if (cdr_lock)  state_d  = StAlignWait;
                    else if (timer_hit) do_retry = 1'b1;
                end
                StAlignWait: begin
                    if (!pll_lock || !cdr_lock) do_retry = 1'b1;
                    else if (rx_aligned)        state_d  = StReady;
                    else if (timer_hit)         do_retry = 1'b1;
                end
                StReady: begin
                    if (!pll_lock || !cdr_lock) do_retry = 1'b1;
                    else if (!rx_aligned)       state_d  = StAlignWait;
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end

        if (do_retry) begin
            if (retry_q < MaxRetries) begin
                retry_d = retry_q + 1'b1;
                state_d = StPllRst;
            end else begin
                state_d = StFault;
                error_d = 1'b1;
            end
        end

        if ((state_d == StReady) && (state_q != StReady)) begin
            retry_d = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        out_d     = state_outputs(state_d);
        busy_d    = !((state_d == StIdle) || (state_d == StReady) || (state_d == StFault));
        timer_clr = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            retry_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= SafeOut;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    serdesphy_seq_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (1'b1),
        .limit(timer_limit),
        .hit  (timer_hit)
    );

    assign iso_en       = out_q.iso_en;
    assign pll_rst      = out_q.pll_rst;
    assign tx_en        = out_q.tx_en;
    assign rx_en        = out_q.rx_en;
    assign cdr_rst      = out_q.cdr_rst;
    assign rx_align_rst = out_q.rx_align_rst;
    assign phy_ready    = out_q.phy_ready;
    assign seq_busy     = busy_q;
    assign seq_error    = error_q;
    assign seq_state    = state_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_serdesphy_link_sequencer.sv
// Directed bench for serdesphy_link_sequencer with shortened timeouts.
module tb_serdesphy_link_sequencer;

    logic       clk = 1'b0;
    logic       rst, phy_en, power_good, por_complete, pll_lock, cdr_lock, rx_aligned;
    logic       iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready;
    logic       seq_busy, seq_error;
    logic [3:0] seq_state, retry_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int pll_rst_entries = 0;
    logic [3:0] prev_state = 4'd0;

    // Output vector order: iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready
    localparam logic [6:0] OutSafe  = 7'b1100110;
    localparam logic [6:0] OutPllR  = 7'b0100110;
    localparam logic [6:0] OutPllW  = 7'b0000110;
    localparam logic [6:0] OutTrx   = 7'b0011110;
    localparam logic [6:0] OutCdr   = 7'b0011010;
    localparam logic [6:0] OutAlign = 7'b0011000;
    localparam logic [6:0] OutReady = 7'b0011001;

    wire [6:0] outs = {iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready};

    always #5 clk = ~clk;

    serdesphy_link_sequencer #(
        .SETTLE_CYCLES(4),
        .PLL_TIMEOUT  (64),
        .CDR_TIMEOUT  (64),
        .ALIGN_TIMEOUT(32),
        .MAX_RETRIES  (2),
        .TIMER_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phy_en      (phy_en),
        .power_good  (power_good),
        .por_complete(por_complete),
        .pll_lock    (pll_lock),
        .cdr_lock    (cdr_lock),
        .rx_aligned  (rx_aligned),
        .iso_en      (iso_en),
        .pll_rst     (pll_rst),
        .tx_en       (tx_en),
        .rx_en       (rx_en),
        .cdr_rst     (cdr_rst),
        .rx_align_rst(rx_align_rst),
        .phy_ready   (phy_ready),
        .seq_busy    (seq_busy),
        .seq_error   (seq_error),
        .seq_state   (seq_state),
        .retry_cnt   (retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (seq_state == 4'd2 && prev_state != 4'd2) pll_rst_entries++;
        prev_state = seq_state;
    endtask

    task automatic expect_steps(input int n, input logic [3:0] st, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, 32'(seq_state), 32'(st));
        end
    endtask

    // PLL_RST settle then PLL_WAIT entry, starting from the PLL_RST entry edge.
    task automatic settle_pll(input string tag);
        expect_steps(3, 4'd2, tag);
        expect_steps(1, 4'd3, tag);
    endtask

    task automatic settle_trx(input string tag);
        expect_steps(3, 4'd4, tag);
        expect_steps(1, 4'd5, tag);
    endtask

    initial begin
        rst = 1'b1; phy_en = 1'b0; power_good = 1'b1; por_complete = 1'b1;
        pll_lock = 1'b0; cdr_lock = 1'b0; rx_aligned = 1'b0;
        step();
        step();
        check("rst_state", 32'(seq_state), 32'd0);
        check("rst_outs", 32'(outs), 32'(OutSafe));
        check("rst_busy", 32'(seq_busy), 32'd0);
        check("rst_err", 32'(seq_error), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);

        // 1. Nominal bring-up
        rst = 1'b0; phy_en = 1'b1;
        step();
        check("t1_pwrwait", 32'(seq_state), 32'd1);
        check("t1_pwrwait_outs", 32'(outs), 32'(OutSafe));
        check("t1_busy", 32'(seq_busy), 32'd1);
        step();
        check("t1_pllrst", 32'(seq_state), 32'd2);
        check("t1_iso_fall", 32'(outs), 32'(OutPllR));
        expect_steps(3, 4'd2, "t1_settle");
        check("t1_pllrst_held", 32'(pll_rst), 32'd1);
        step();
        check("t1_pllwait", 32'(seq_state), 32'd3);
        check("t1_pllwait_outs", 32'(outs), 32'(OutPllW));
        expect_steps(10, 4'd3, "t1_pllwait_hold");
        pll_lock = 1'b1;
        step();
        check("t1_trx", 32'(seq_state), 32'd4);
        check("t1_trx_outs", 32'(outs), 32'(OutTrx));
        settle_trx("t1_trx_settle");
        check("t1_cdr_outs", 32'(outs), 32'(OutCdr));
        cdr_lock = 1'b1;
        step();
        check("t1_align", 32'(seq_state), 32'd6);
        check("t1_align_outs", 32'(outs), 32'(OutAlign));
        rx_aligned = 1'b1;
        step();
        check("t1_ready", 32'(seq_state), 32'd7);
        check("t1_ready_outs", 32'(outs), 32'(OutReady));
        check("t1_retry", 32'(retry_cnt), 32'd0);
        check("t1_busy_ready", 32'(seq_busy), 32'd0);

        // 3. cdr_lock drop in READY
        cdr_lock = 1'b0;
        step();
        check("t3_pllrst", 32'(seq_state), 32'd2);
        check("t3_retry", 32'(retry_cnt), 32'd1);
        check("t3_ready_low", 32'(phy_ready), 32'd0);
        cdr_lock = 1'b1;
        settle_pll("t3_relock_pll");
        step();
        check("t3_trx", 32'(seq_state), 32'd4);
        settle_trx("t3_relock_trx");
        step();
        check("t3_align", 32'(seq_state), 32'd6);
        step();
        check("t3_ready", 32'(seq_state), 32'd7);
        check("t3_retry_clr", 32'(retry_cnt), 32'd0);

        // 4. rx_aligned drop in READY
        rx_aligned = 1'b0;
        step();
        check("t4_align", 32'(seq_state), 32'd6);
        check("t4_outs", 32'(outs), 32'(OutAlign));
        check("t4_retry", 32'(retry_cnt), 32'd0);
        rx_aligned = 1'b1;
        step();
        check("t4_ready", 32'(seq_state), 32'd7);

        // 5. power_good falls in CDR_WAIT (entered via one retry so retry_cnt=1)
        pll_lock = 1'b0; cdr_lock = 1'b0;
        step();
        check("t5_retry_pllrst", 32'(seq_state), 32'd2);
        pll_lock = 1'b1;
        settle_pll("t5_pll");
        step();
        settle_trx("t5_trx");
        power_good = 1'b0;
        step();
        check("t5_pwrwait", 32'(seq_state), 32'd1);
        check("t5_iso", 32'(iso_en), 32'd1);
        check("t5_outs", 32'(outs), 32'(OutSafe));
        check("t5_retry", 32'(retry_cnt), 32'd1);
        step();
        check("t5_pwrwait_hold", 32'(seq_state), 32'd1);
        power_good = 1'b1;
        step();
        check("t5_resume", 32'(seq_state), 32'd2);
        check("t5_retry_keep", 32'(retry_cnt), 32'd1);
        settle_pll("t5_pll2");
        step();
        settle_trx("t5_trx2");
        cdr_lock = 1'b1;
        step();
        step();
        check("t5_ready", 32'(seq_state), 32'd7);
        check("t5_retry_clr", 32'(retry_cnt), 32'd0);

        // 6a. pll_lock arrives exactly at timer=63
        pll_lock = 1'b0;
        step();
        check("t6_pllrst", 32'(seq_state), 32'd2);
        settle_pll("t6_pll");
        expect_steps(63, 4'd3, "t6_pllwait");
        pll_lock = 1'b1;
        step();
        check("t6_trx_edge", 32'(seq_state), 32'd4);
        check("t6_no_retry", 32'(retry_cnt), 32'd1);
        settle_trx("t6_trx");
        step();
        step();
        check("t6_ready", 32'(seq_state), 32'd7);

        // 6b. rst pulsed in READY
        rst = 1'b1;
        step();
        check("t6b_state", 32'(seq_state), 32'd0);
        check("t6b_outs", 32'(outs), 32'(OutSafe));
        check("t6b_busy", 32'(seq_busy), 32'd0);
        check("t6b_err", 32'(seq_error), 32'd0);
        check("t6b_retry", 32'(retry_cnt), 32'd0);

        // 2. PLL never locks
        rst = 1'b0; pll_lock = 1'b0; cdr_lock = 1'b0; rx_aligned = 1'b0;
        pll_rst_entries = 0;
        step();
        check("t2_pwrwait", 32'(seq_state), 32'd1);
        step();
        check("t2_pllrst", 32'(seq_state), 32'd2);
        for (int a = 0; a < 3; a++) begin
            settle_pll("t2_settle");
            expect_steps(63, 4'd3, "t2_pllwait");
            step();
            if (a < 2) begin
                check("t2_retry_state", 32'(seq_state), 32'd2);
                check("t2_retry_cnt", 32'(retry_cnt), 32'(a + 1));
            end
        end
        check("t2_fault", 32'(seq_state), 32'd8);
        check("t2_err", 32'(seq_error), 32'd1);
        check("t2_retry_final", 32'(retry_cnt), 32'd2);
        check("t2_safe", 32'(outs), 32'(OutSafe));
        check("t2_busy", 32'(seq_busy), 32'd0);
        check("t2_entries", 32'(pll_rst_entries), 32'd3);
        pll_lock = 1'b1;
        expect_steps(2, 4'd8, "t2_fault_hold");
        phy_en = 1'b0;
        step();
        check("t2_idle", 32'(seq_state), 32'd0);
        check("t2_err_clr", 32'(seq_error), 32'd0);
        check("t2_retry_clr", 32'(retry_cnt), 32'd0);
        check("t2_idle_outs", 32'(outs), 32'(OutSafe));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
